// File: rtl/test_result_checker.sv
// Streaming result checker: buffers expected words, compares them in order against the DUT stream,
// and reports pass/fail. Define TEST_CHECKER_WATCHDOG_EN to enable the no-progress watchdog.
module test_result_checker #(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_OUTPUTS = 64,
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT     = 1000,
  localparam int CW         = $clog2(NUM_OUTPUTS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  exp_valid,
  input  logic [DATA_WIDTH-1:0] exp_data,
  output logic                  exp_ready,
  input  logic                  dut_valid,
  input  logic [DATA_WIDTH-1:0] dut_data,
  output logic                  dut_ready,
  output logic                  busy,
  output logic                  pass,
  output logic                  fail,
  output logic                  timed_out,
  output logic [CW-1:0]         error_count,
  output logic [CW-1:0]         checked_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST_CHECK = CW'(NUM_OUTPUTS);

  typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  mismatch;
  logic [CW-1:0]         checked_next;
  logic [CW-1:0]         error_next;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  assign exp_ready = (state == RUN) && !full;
  assign dut_ready = (state == RUN) && !empty;
  assign push      = exp_valid && exp_ready;
  assign pop       = dut_valid && dut_ready;

  assign mismatch     = (mem[rd_ptr[AW-1:0]] != dut_data);
  assign checked_next = checked_count + CW'(1);
  assign error_next   = error_count + CW'(mismatch);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= exp_data;
    end
  end

`ifdef TEST_CHECKER_WATCHDOG_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);
  logic [WW-1:0] wd_count;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      busy          <= 1'b0;
      pass          <= 1'b0;
      fail          <= 1'b0;
      timed_out     <= 1'b0;
      error_count   <= '0;
      checked_count <= '0;
`ifdef TEST_CHECKER_WATCHDOG_EN
      wd_count      <= '0;
`endif
    end else if (start) begin
      state         <= RUN;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      busy          <= 1'b1;
      pass          <= 1'b0;
      fail          <= 1'b0;
      timed_out     <= 1'b0;
      error_count   <= '0;
      checked_count <= '0;
`ifdef TEST_CHECKER_WATCHDOG_EN
      wd_count      <= '0;
`endif
    end else if (state == RUN) begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr        <= rd_ptr + 1'b1;
        checked_count <= checked_next;
        error_count   <= error_next;
        // Completion is decided on the post-update error count.
        if (checked_next == LAST_CHECK) begin
          busy <= 1'b0;
          if (error_next == '0) begin
            state <= PASS;
            pass  <= 1'b1;
          end else begin
            state <= FAIL;
            fail  <= 1'b1;
          end
        end
      end
`ifdef TEST_CHECKER_WATCHDOG_EN
      // A handshake always clears the watchdog, so a completing compare beats the timeout.
      if (pop) begin
        wd_count <= '0;
      end else if (wd_count == WD_LAST) begin
        state     <= FAIL;
        busy      <= 1'b0;
        fail      <= 1'b1;
        timed_out <= 1'b1;
      end else begin
        wd_count <= wd_count + 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_test_result_checker.sv
// Directed bench for test_result_checker (NUM_OUTPUTS=4, FIFO_DEPTH=2, TIMEOUT=10).
module tb_test_result_checker;

  localparam int DW = 16;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          exp_valid;
  logic [DW-1:0] exp_data;
  logic          exp_ready;
  logic          dut_valid;
  logic [DW-1:0] dut_data;
  logic          dut_ready;
  logic          busy;
  logic          pass;
  logic          fail;
  logic          timed_out;
  logic [CW-1:0] error_count;
  logic [CW-1:0] checked_count;

  int checks   = 0;
  int failures = 0;

  test_result_checker #(
    .DATA_WIDTH(DW), .NUM_OUTPUTS(4), .FIFO_DEPTH(2), .TIMEOUT(10)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .exp_valid(exp_valid), .exp_data(exp_data), .exp_ready(exp_ready),
    .dut_valid(dut_valid), .dut_data(dut_data), .dut_ready(dut_ready),
    .busy(busy), .pass(pass), .fail(fail), .timed_out(timed_out),
    .error_count(error_count), .checked_count(checked_count)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_status(input string tag, input int b, input int p, input int f,
                            input int t, input int e, input int c);
    chk({tag, ".busy"}, int'(busy), b);
    chk({tag, ".pass"}, int'(pass), p);
    chk({tag, ".fail"}, int'(fail), f);
    chk({tag, ".timed_out"}, int'(timed_out), t);
    chk({tag, ".error_count"}, int'(error_count), e);
    chk({tag, ".checked_count"}, int'(checked_count), c);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // One expected push followed by one DUT compare; dut_ready must be high for the compare.
  task automatic xfer(input string tag, input logic [DW-1:0] e, input logic [DW-1:0] d);
    exp_valid = 1'b1;
    exp_data  = e;
    tick();
    exp_valid = 1'b0;
    chk({tag, ".dut_ready"}, int'(dut_ready), 1);
    dut_valid = 1'b1;
    dut_data  = d;
    tick();
    dut_valid = 1'b0;
    $display("xfer %s exp=%0d dut=%0d err=%0d chk=%0d", tag, e, d, error_count, checked_count);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; exp_valid = 1'b0; exp_data = '0; dut_valid = 1'b0; dut_data = '0;
    tick();
    tick();
    chk_status("reset", 0, 0, 0, 0, 0, 0);
    chk("reset.exp_ready", int'(exp_ready), 0);
    chk("reset.dut_ready", int'(dut_ready), 0);

    // rst and start together: rst wins.
    start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    chk("rst_start.busy", int'(busy), 0);

    // Matching stream.
    do_start();
    chk_status("run0", 1, 0, 0, 0, 0, 0);
    chk("run0.exp_ready", int'(exp_ready), 1);
    chk("run0.dut_ready", int'(dut_ready), 0);
    xfer("m1", 16'd1, 16'd1);
    xfer("m2", 16'd2, 16'd2);
    xfer("m3", 16'd3, 16'd3);
    chk_status("m3", 1, 0, 0, 0, 0, 3);
    xfer("m4", 16'd4, 16'd4);
    chk_status("pass", 0, 1, 0, 0, 0, 4);
    tick();
    chk("pass_hold", int'(pass), 1);

    // Start while in PASS clears everything.
    do_start();
    chk_status("restart", 1, 0, 0, 0, 0, 0);

    // One mismatching word.
    xfer("x1", 16'd1, 16'd1);
    xfer("x2", 16'd2, 16'd2);
    xfer("x3", 16'd3, 16'd9);
    chk_status("x3", 1, 0, 0, 0, 1, 3);
    xfer("x4", 16'd4, 16'd4);
    chk_status("fail", 0, 0, 1, 0, 1, 4);

    // FIFO full behaviour with depth 2.
    do_start();
    exp_valid = 1'b1; exp_data = 16'd10;
    tick();
    exp_data = 16'd20;
    tick();
    chk("full.exp_ready", int'(exp_ready), 0);
    exp_data = 16'd30; dut_valid = 1'b1; dut_data = 16'd10;
    tick();
    exp_valid = 1'b0;
    chk("pushpop.exp_ready", int'(exp_ready), 1);
    chk("pushpop.dut_ready", int'(dut_ready), 1);
    chk_status("pushpop", 1, 0, 0, 0, 0, 1);
    dut_data = 16'd20;
    tick();
    dut_valid = 1'b0;
    chk("refused.dut_ready", int'(dut_ready), 0);
    chk_status("refused", 1, 0, 0, 0, 0, 2);

    // Reset mid-test after two compares.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_status("midrst", 0, 0, 0, 0, 0, 0);
    chk("midrst.dut_ready", int'(dut_ready), 0);
    chk("midrst.exp_ready", int'(exp_ready), 0);
    do_start();
    xfer("r1", 16'h00AA, 16'h00AA);
    xfer("r2", 16'h1234, 16'h1234);
    xfer("r3", 16'hFFFF, 16'hFFFF);
    xfer("r4", 16'h8000, 16'h8000);
    chk_status("rpass", 0, 1, 0, 0, 0, 4);

    // Watchdog: one word pushed, DUT stays silent.
    do_start();
    exp_valid = 1'b1; exp_data = 16'd5;
    tick();
    exp_valid = 1'b0;
    for (int i = 2; i < 10; i++) tick();
    chk("wd9.fail", int'(fail), 0);
    tick();
`ifdef TEST_CHECKER_WATCHDOG_EN
    chk_status("wd10", 0, 0, 1, 1, 0, 0);
`else
    for (int i = 0; i < 10; i++) tick();
    chk_status("nowd", 1, 0, 0, 0, 0, 0);
    chk("nowd.dut_ready", int'(dut_ready), 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
